// File: rtl/os_systolic_engine_if.sv
// Operand and result streams of the output-stationary engine.
// The engine sits on the slave side; the feeder/consumer on master.
interface os_systolic_engine_if #(
    parameter int ROW        = 4,
    parameter int COL        = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int RW         = (ROW > 1) ? $clog2(ROW) : 1
);
    logic                      in_valid;
    logic                      in_ready;
    logic [ROW*DATA_WIDTH-1:0] in_a;
    logic [COL*DATA_WIDTH-1:0] in_b;
    logic                      out_valid;
    logic                      out_ready;
    logic [COL*ACC_WIDTH-1:0]  out_data;
    logic [RW-1:0]             out_row;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_row
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_row
    );
endinterface

// File: rtl/os_systolic_engine.sv
// Output-stationary systolic matrix-multiply engine.
// K-slices stream in, C rows stream out one per handshake.
module os_systolic_engine #(
    parameter int ROW        = 4,
    parameter int COL        = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int K_MAX      = 16,
    parameter int KW         = $clog2(K_MAX + 1),
    parameter int RW         = (ROW > 1) ? $clog2(ROW) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KW-1:0]       k_len,
    input  logic                signed_mode,
    os_systolic_engine_if.slave io,
    output logic                busy,
    output logic                done
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int PW = 2 * DW + 2;
    localparam int EW = (AW > PW) ? AW : PW;
    localparam int DL = ROW + COL - 2;
    localparam int CW = $clog2(ROW + COL);

    localparam logic [CW-1:0] D_LAST = CW'((DL > 0) ? DL - 1 : 0);
    localparam logic [KW-1:0] K_SAT  = KW'(K_MAX);
    localparam logic [RW-1:0] R_LAST = RW'(ROW - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        OUT
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [KW-1:0] k_q;
    logic [KW-1:0] k_eff;
    logic [KW-1:0] t_q;
    logic [CW-1:0] d_q;
    logic [RW-1:0] r_q;
    logic          sm_q;

    logic in_rdy;
    logic out_vld;
    logic adv;
    logic clr;
    logic drain;

    logic [DW-1:0] sa    [ROW][ROW];
    logic [DW-1:0] sb    [COL][COL];
    logic [DW-1:0] inj_a [ROW];
    logic [DW-1:0] inj_b [COL];
    logic [DW-1:0] a_w   [ROW];
    logic [DW-1:0] b_n   [COL];
    logic [DW-1:0] a_r   [ROW][COL];
    logic [DW-1:0] b_r   [ROW][COL];
    logic [DW-1:0] a_pe  [ROW][COL];
    logic [DW-1:0] b_pe  [ROW][COL];
    logic [AW-1:0] term  [ROW][COL];
    logic [AW-1:0] acc   [ROW][COL];

    assign k_eff = (k_len > K_SAT) ? K_SAT : k_len;
    assign drain = (state_q == DRAIN);
    assign busy  = (state_q != IDLE);

    assign io.in_ready  = in_rdy;
    assign io.out_valid = out_vld;
    assign io.out_row   = out_vld ? r_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        adv     = 1'b0;
        clr     = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = (k_eff != '0) ? LOAD : OUT;
                end
            end
            LOAD: begin
                in_rdy = 1'b1;
                if (io.in_valid) begin
                    adv = 1'b1;
                    if (t_q == k_q - KW'(1)) begin
                        state_d = (DL == 0) ? OUT : DRAIN;
                    end
                end
            end
            DRAIN: begin
                adv = 1'b1;
                if (d_q == D_LAST) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_vld = 1'b1;
                if (io.out_ready && r_q == R_LAST) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q  <= '0;
            sm_q <= 1'b0;
            t_q  <= '0;
            d_q  <= '0;
            r_q  <= '0;
        end else begin
            if (clr) begin
                k_q  <= k_eff;
                sm_q <= signed_mode;
                t_q  <= '0;
                d_q  <= '0;
                r_q  <= '0;
            end
            if (in_rdy && adv) begin
                t_q <= t_q + KW'(1);
            end
            if (drain) begin
                d_q <= d_q + CW'(1);
            end
            if (out_vld && io.out_ready) begin
                r_q <= r_q + RW'(1);
            end
        end
    end

    // Edge injection: zeros while draining so the tail flushes cleanly.
    always_comb begin
        for (int i = 0; i < ROW; i++) begin
            inj_a[i] = drain ? '0 : io.in_a[i*DW +: DW];
            if (i == 0) begin
                a_w[i] = inj_a[i];
            end else begin
                a_w[i] = sa[i][i-1];
            end
        end
        for (int j = 0; j < COL; j++) begin
            inj_b[j] = drain ? '0 : io.in_b[j*DW +: DW];
            if (j == 0) begin
                b_n[j] = inj_b[j];
            end else begin
                b_n[j] = sb[j][j-1];
            end
        end
    end

    function automatic logic [AW-1:0] mac_term(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic          sm
    );
        logic signed [PW-1:0] ea;
        logic signed [PW-1:0] eb;
        logic signed [PW-1:0] p;
        logic signed [EW-1:0] pw;
        ea = {{(PW-DW){sm & a[DW-1]}}, a};
        eb = {{(PW-DW){sm & b[DW-1]}}, b};
        p  = ea * eb;
        pw = EW'(p);
        return pw[AW-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < ROW; i++) begin
            for (int j = 0; j < COL; j++) begin
                if (j == 0) begin
                    a_pe[i][j] = a_w[i];
                end else begin
                    a_pe[i][j] = a_r[i][j-1];
                end
                if (i == 0) begin
                    b_pe[i][j] = b_n[j];
                end else begin
                    b_pe[i][j] = b_r[i-1][j];
                end
                term[i][j] = mac_term(a_pe[i][j], b_pe[i][j], sm_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROW; i++) begin
                for (int k = 0; k < ROW; k++) sa[i][k] <= '0;
            end
            for (int j = 0; j < COL; j++) begin
                for (int k = 0; k < COL; k++) sb[j][k] <= '0;
            end
            for (int i = 0; i < ROW; i++) begin
                for (int j = 0; j < COL; j++) begin
                    a_r[i][j] <= '0;
                    b_r[i][j] <= '0;
                    acc[i][j] <= '0;
                end
            end
        end else if (clr) begin
            for (int i = 0; i < ROW; i++) begin
                for (int k = 0; k < ROW; k++) sa[i][k] <= '0;
            end
            for (int j = 0; j < COL; j++) begin
                for (int k = 0; k < COL; k++) sb[j][k] <= '0;
            end
            for (int i = 0; i < ROW; i++) begin
                for (int j = 0; j < COL; j++) begin
                    a_r[i][j] <= '0;
                    b_r[i][j] <= '0;
                    acc[i][j] <= '0;
                end
            end
        end else if (adv) begin
            for (int i = 0; i < ROW; i++) begin
                sa[i][0] <= inj_a[i];
                for (int k = 1; k < ROW; k++) begin
                    if (k < i) sa[i][k] <= sa[i][k-1];
                end
            end
            for (int j = 0; j < COL; j++) begin
                sb[j][0] <= inj_b[j];
                for (int k = 1; k < COL; k++) begin
                    if (k < j) sb[j][k] <= sb[j][k-1];
                end
            end
            for (int i = 0; i < ROW; i++) begin
                for (int j = 0; j < COL; j++) begin
                    a_r[i][j] <= a_pe[i][j];
                    b_r[i][j] <= b_pe[i][j];
                    acc[i][j] <= acc[i][j] + term[i][j];
                end
            end
        end
    end

    always_comb begin
        io.out_data = '0;
        if (out_vld) begin
            for (int j = 0; j < COL; j++) begin
                io.out_data[j*AW +: AW] = acc[r_q][j];
            end
        end
    end
endmodule
